// File: rtl/elev_ctrl_pkg.sv
// Shared types and sizes for the elevator controller.
package elev_ctrl_pkg;

  localparam int unsigned NUM_FLOORS = 4;
  localparam int unsigned FLOOR_W    = $clog2(NUM_FLOORS);

  typedef logic [FLOOR_W-1:0] floor_t;

  typedef enum logic [0:0] {
    OPEN = 1'b0,
    MOVE = 1'b1
  } state_t;

endpackage : elev_ctrl_pkg

// File: rtl/elev_ctrl_if.sv
// Panel/actuator bundle for the elevator controller.
//   floorBtn : request vector, bit i requests floor index i
//   floorSel : current floor index
//   door     : 1 = door open
// master = panel/actuator side, slave = controller.
interface elev_ctrl_if;
  import elev_ctrl_pkg::*;

  logic [NUM_FLOORS-1:0] floorBtn;
  floor_t                floorSel;
  logic                  door;

  modport master (output floorBtn, input  floorSel, input  door);
  modport slave  (input  floorBtn, output floorSel, output door);

endinterface : elev_ctrl_if

// File: rtl/elev_btn_enc.sv
// Lowest-index-wins priority encoder for the floor request buttons.
//   btn_i   : request vector
//   valid_c : at least one request is set
//   idx_c   : index of the lowest set request bit (0 when none)
module elev_btn_enc
  import elev_ctrl_pkg::*;
(
  input  logic [NUM_FLOORS-1:0] btn_i,
  output logic                  valid_c,
  output floor_t                idx_c
);

  // Scan from the top down so the lowest set bit is the last to win.
  always_comb begin
    valid_c = 1'b0;
    idx_c   = '0;
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      if (btn_i[i]) begin
        valid_c = 1'b1;
        idx_c   = FLOOR_W'(i);
      end
    end
  end

endmodule : elev_btn_enc

// File: rtl/elev_ctrl.sv
// Single-car elevator controller: latches a destination from the panel,
// steps one floor per clock with the door closed, opens on arrival.
//   clk : system clock
//   rst : synchronous active-high reset (car to floor 0, door open)
//   bus : slave side of elev_ctrl_if (floorBtn in; floorSel, door out)
module elev_ctrl
  import elev_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  elev_ctrl_if.slave  bus
);

  state_t state_q, state_d;
  floor_t sel_q,   sel_d;
  floor_t tgt_q,   tgt_d;
  logic   door_q,  door_d;

  logic   req_valid_c;
  floor_t req_idx_c;
  logic   depart_c;

  elev_btn_enc u_enc (
    .btn_i   (bus.floorBtn),
    .valid_c (req_valid_c),
    .idx_c   (req_idx_c)
  );

  // A request for the floor the car is already at is not a trip.
  assign depart_c = req_valid_c && (req_idx_c != sel_q);

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= OPEN;
      sel_q   <= '0;
      tgt_q   <= '0;
      door_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      tgt_q   <= tgt_d;
      door_q  <= door_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      OPEN:    if (depart_c) state_d = MOVE;
      MOVE:    if (sel_q == tgt_q) state_d = OPEN;
      default: state_d = OPEN;
    endcase
  end

  // Next values of the registered outputs and the latched target.
  always_comb begin
    sel_d  = sel_q;
    tgt_d  = tgt_q;
    door_d = door_q;
    unique case (state_q)
      OPEN: begin
        if (depart_c) begin
          tgt_d  = req_idx_c;
          door_d = 1'b0;
        end else begin
          door_d = 1'b1;
        end
      end
      MOVE: begin
        if (sel_q != tgt_q) begin
          sel_d  = (tgt_q > sel_q) ? sel_q + FLOOR_W'(1) : sel_q - FLOOR_W'(1);
          door_d = 1'b0;
        end else begin
          door_d = 1'b1;
        end
      end
      default: door_d = 1'b1;
    endcase
  end

  assign bus.floorSel = sel_q;
  assign bus.door     = door_q;

endmodule : elev_ctrl

// File: tb/tb_elev_ctrl.sv
// Self-checking bench for elev_ctrl: directed trips with literal
// expectations plus randomized requests checked against a trip model.
module tb_elev_ctrl;

  logic clk = 1'b0;
  logic rst;

  elev_ctrl_if bus ();

  elev_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: car position, door, and pending destination (-1 = idle).
  int m_pos  = 0;
  int m_door = 1;
  int m_dest = -1;
  bit chk_en = 1'b0;

  function automatic int lowest_req(input logic [3:0] b);
    int r;
    r = -1;
    for (int i = 3; i >= 0; i--) if (b[i]) r = i;
    return r;
  endfunction

  task automatic model_step(input logic [3:0] b, input logic r);
    int req;
    if (r) begin
      m_pos = 0; m_door = 1; m_dest = -1;
    end else if (m_dest < 0) begin
      req = lowest_req(b);
      if (req >= 0 && req != m_pos) begin
        m_dest = req; m_door = 0;
      end else begin
        m_door = 1;
      end
    end else if (m_pos != m_dest) begin
      m_pos  = m_pos + ((m_dest > m_pos) ? 1 : -1);
      m_door = 0;
    end else begin
      m_door = 1; m_dest = -1;
    end
  endtask

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      n_cmp++;
      if (int'(bus.floorSel) != m_pos || int'(bus.door) != m_door) begin
        n_bad++;
        $display("FAIL model t=%0t: got sel=%0d door=%0d, want sel=%0d door=%0d",
                 $time, bus.floorSel, bus.door, m_pos, m_door);
      end
    end
  end

  // One clock: apply inputs, advance model at the edge, settle to negedge.
  task automatic cyc(input logic [3:0] b, input logic r);
    bus.floorBtn = b;
    rst          = r;
    @(posedge clk);
    model_step(b, r);
    chk_en = 1'b1;
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input int sel, input int d);
    n_cmp++;
    if (int'(bus.floorSel) != sel || int'(bus.door) != d) begin
      n_bad++;
      $display("FAIL %s: got sel=%0d door=%0d, want sel=%0d door=%0d",
               nm, bus.floorSel, bus.door, sel, d);
    end
  endtask

  task automatic hop(input string nm, input logic [3:0] b, input int from, input int to);
    cyc(b, 1'b0); chk({nm, "_e1"}, from, 0);
    cyc(b, 1'b0); chk({nm, "_e2"}, to,   0);
    cyc(b, 1'b0); chk({nm, "_e3"}, to,   1);
  endtask

  initial begin
    logic [3:0] rb;
    int hold;
    bus.floorBtn = 4'b0001;
    rst          = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 3; i++) begin cyc(4'b0001, 1'b1); chk("reset", 0, 1); end
    for (int i = 0; i < 3; i++) begin cyc(4'b0001, 1'b0); chk("post_reset", 0, 1); end

    hop("hop01", 4'b0010, 0, 1);
    hop("hop12", 4'b0100, 1, 2);
    hop("hop23", 4'b1000, 2, 3);
    hop("hop32", 4'b0100, 3, 2);
    hop("hop21", 4'b0010, 2, 1);
    hop("hop10", 4'b0001, 1, 0);

    // Full-height trips up and down.
    cyc(4'b1000, 1'b0); chk("up_e1", 0, 0);
    cyc(4'b1000, 1'b0); chk("up_e2", 1, 0);
    cyc(4'b1000, 1'b0); chk("up_e3", 2, 0);
    cyc(4'b1000, 1'b0); chk("up_e4", 3, 0);
    cyc(4'b1000, 1'b0); chk("up_e5", 3, 1);
    cyc(4'b0001, 1'b0); chk("dn_e1", 3, 0);
    cyc(4'b0001, 1'b0); chk("dn_e2", 2, 0);
    cyc(4'b0001, 1'b0); chk("dn_e3", 1, 0);
    cyc(4'b0001, 1'b0); chk("dn_e4", 0, 0);
    cyc(4'b0001, 1'b0); chk("dn_e5", 0, 1);

    for (int i = 0; i < 3; i++) begin cyc(4'b0000, 1'b0); chk("idle_none", 0, 1); end
    for (int i = 0; i < 3; i++) begin cyc(4'b0001, 1'b0); chk("idle_here", 0, 1); end

    // Request change during travel is ignored, then serviced from OPEN.
    cyc(4'b0100, 1'b0); chk("chg_e1", 0, 0);
    cyc(4'b1000, 1'b0); chk("chg_e2", 1, 0);
    cyc(4'b1000, 1'b0); chk("chg_e3", 2, 0);
    cyc(4'b1000, 1'b0); chk("chg_e4", 2, 1);
    cyc(4'b1000, 1'b0); chk("chg_e5", 2, 0);
    cyc(4'b1000, 1'b0); chk("chg_e6", 3, 0);
    cyc(4'b1000, 1'b0); chk("chg_e7", 3, 1);

    cyc(4'b0000, 1'b1); chk("rst_home", 0, 1);
    cyc(4'b1010, 1'b0); chk("multi_e1", 0, 0);
    cyc(4'b1010, 1'b0); chk("multi_e2", 1, 0);
    cyc(4'b1010, 1'b0); chk("multi_e3", 1, 1);

    // Reset mid-travel returns the car home at once.
    cyc(4'b1000, 1'b0); chk("midrst_e1", 1, 0);
    cyc(4'b1000, 1'b0); chk("midrst_e2", 2, 0);
    cyc(4'b1000, 1'b1); chk("midrst_rst", 0, 1);
    cyc(4'b0000, 1'b0); chk("midrst_after", 0, 1);

    // Randomized requests, held for a few cycles, with rare resets.
    for (int n = 0; n < 60; n++) begin
      rb   = 4'($urandom_range(0, 15));
      hold = int'($urandom_range(1, 8));
      for (int k = 0; k < hold; k++) begin
        if ($urandom_range(0, 7) == 0) rb = 4'($urandom_range(0, 15));
        cyc(rb, ($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0);
      end
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_elev_ctrl
